// File: rtl/wb_stage.sv
// RV32I writeback stage: selects ALU / PC+4 / load result and issues a single-cycle
// register-file write; loads wait for the data-memory response and are aligned/extended here.
module wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_err,
  output logic        timeout_err
);

  typedef enum logic [0:0] {S_IDLE, S_WAIT_LOAD} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic        w_accept;
  logic        w_load_illegal;
  logic [31:0] w_load_data;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] alo,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*alo +: 8];
    h = alo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  // Undefined funct3 encodings, odd halfword addresses and non-word-aligned LW are rejected.
  assign w_load_illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111)
                       || (((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) && in_addr_lo[0])
                       || ((in_funct3 == 3'b010) && (in_addr_lo != 2'b00));

  assign w_load_data = extract(r_funct3, r_addr_lo, dmem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_rd        <= 5'd0;
      r_funct3    <= 3'd0;
      r_addr_lo   <= 2'd0;
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      load_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle via non-blocking assignment; a later
      // assignment in this block overrides the default without creating a race or latch.
      rf_we       <= 1'b0;
      load_err    <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (in_wb_sel)
              SEL_ALU, SEL_PC4: begin
                if (in_rd != 5'd0) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= in_rd;
                  rf_wdata <= (in_wb_sel == SEL_PC4) ? in_pc_plus4 : in_alu_result;
                end
              end
              SEL_LOAD: begin
                if (w_load_illegal) begin
                  load_err <= 1'b1;
                end else begin
                  r_rd      <= in_rd;
                  r_funct3  <= in_funct3;
                  r_addr_lo <= in_addr_lo;
                  r_cnt     <= 8'd0;
                  r_state   <= S_WAIT_LOAD;
                end
              end
              default: ;
            endcase
          end
        end
        S_WAIT_LOAD: begin
          if (dmem_rvalid) begin
            r_state <= S_IDLE;
            if (r_rd != 5'd0) begin
              rf_we    <= 1'b1;
              rf_waddr <= r_rd;
              rf_wdata <= w_load_data;
            end
          end else if ((TIMEOUT != 0) && (r_cnt == TO_LAST)) begin
            r_state     <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
